// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte-wide RAM and IO window responder for the byte-serial memory bus
// One-cycle registered read data, TX/RX byte FIFOs behind the IO window at address[17:16]==2'b11.
module mem_io_responder #(
  parameter int    ADDR_W    = 17,
  parameter int    TX_DEPTH  = 16,
  parameter int    RX_DEPTH  = 16,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_full,
  output logic        tx_overflow,
  output logic        sim_end
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  logic [7:0] ram [2**ADDR_W];

  logic              is_io, io_wr, io_rd;
  logic [2:0]        io_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              unused_addr;

  assign is_io       = (mem_a[17:16] == 2'b11);
  assign io_wr       = is_io && mem_wr;
  assign io_rd       = is_io && !mem_wr;
  assign io_off      = mem_a[2:0];
  assign ram_idx     = mem_a[ADDR_W-1:0];
  assign unused_addr = ^mem_a[31:18];

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count, tx_count_next;
  logic             tx_full, tx_push, tx_pop;

  assign tx_full       = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign tx_valid      = (tx_count != '0);
  assign tx_data       = tx_mem[tx_rd_ptr];
  assign tx_push       = io_wr && (io_off == 3'd0) && !tx_full;
  assign tx_pop        = tx_valid && tx_ready;
  assign tx_count_next = tx_count + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_nonempty, rx_push, rx_pop;

  assign rx_full     = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign rx_nonempty = (rx_count != '0);
  assign rx_push     = rx_valid && !rx_full;
  assign rx_pop      = io_rd && (io_off == 3'd0) && rx_nonempty;

  always_ff @(posedge clk) begin
    if (!is_io && mem_wr) ram[ram_idx] <= mem_dout;
    if (tx_push) tx_mem[tx_wr_ptr] <= mem_dout;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // Read-first: a RAM write cycle returns the byte being overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_din <= '0;
    end else if (!is_io) begin
      mem_din <= ram[ram_idx];
    end else if (mem_wr) begin
      mem_din <= '0;
    end else begin
      case (io_off)
        3'd0:    mem_din <= rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
        3'd4:    mem_din <= {6'b0, rx_nonempty, tx_full};
        default: mem_din <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
      sim_end        <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_count       <= tx_count_next;
      // One slot of margin covers an IO write already in flight when the flag rises.
      io_buffer_full <= (tx_count_next >= (TX_AW+1)'(TX_DEPTH-1));
      if (io_wr && (io_off == 3'd0) && tx_full) tx_overflow <= 1'b1;
      if (io_wr && (io_off == 3'd4))            sim_end     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      rx_count <= rx_count + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder
// Queue/array reference model updated per bus cycle, compared every cycle after the edge.
module tb_mem_io_responder;
  localparam int ADDR_W   = 17;
  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;
  localparam logic [31:0] A_IO0  = 32'h0003_0000;
  localparam logic [31:0] A_IO4  = 32'h0003_0004;
  localparam logic [31:0] A_IDLE = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout, mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_full, tx_overflow, sim_end;

  always #5 clk = ~clk;

  mem_io_responder #(.ADDR_W(ADDR_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full), .tx_overflow(tx_overflow),
    .sim_end(sim_end)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] ram_m [int];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic       exp_ovf = 1'b0, exp_end = 1'b0, din_known = 1'b0, chk_en = 1'b0;
  logic [7:0] exp_din = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (din_known) check("mem_din", mem_din, exp_din);
    check("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
    check("io_buffer_full", io_buffer_full, tx_q.size() >= TX_DEPTH - 1);
    check("rx_full", rx_full, rx_q.size() == RX_DEPTH);
    check("tx_overflow", tx_overflow, exp_ovf);
    check("sim_end", sim_end, exp_end);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) compare_model();
  end

  // Drive one bus cycle at the falling edge and advance the model to its post-edge state.
  task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic txr, input logic [7:0] rxd, input logic rxv);
    logic io, txf;
    int   rxn, idx;
    @(negedge clk);
    rst = 1'b0; mem_a = a; mem_wr = wr; mem_dout = d;
    tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    io  = (a[17:16] == 2'b11);
    txf = (tx_q.size() == TX_DEPTH);
    rxn = rx_q.size();
    din_known = 1'b1;
    exp_din   = 8'h00;
    if (!io) begin
      idx = int'(a[ADDR_W-1:0]);
      if (ram_m.exists(idx)) exp_din = ram_m[idx];
      else din_known = 1'b0;
      if (wr) ram_m[idx] = d;
    end else if (wr) begin
      if (a[2:0] == 3'd0 && txf) exp_ovf = 1'b1;
      if (a[2:0] == 3'd4) exp_end = 1'b1;
    end else begin
      if (a[2:0] == 3'd0 && rxn != 0) exp_din = rx_q.pop_front();
      else if (a[2:0] == 3'd4) exp_din = {6'b0, rxn != 0, txf};
    end
    if (tx_q.size() != 0 && txr) void'(tx_q.pop_front());
    if (io && wr && a[2:0] == 3'd0 && !txf) tx_q.push_back(d);
    if (rxv && rxn != RX_DEPTH) rx_q.push_back(rxd);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_a = A_IDLE; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_q.delete(); rx_q.delete();
    exp_ovf = 1'b0; exp_end = 1'b0; exp_din = 8'h00; din_known = 1'b1; chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic rand_cycle(input int p_io, input int p_wr, input int p_txr, input int p_rxv);
    logic [31:0] a;
    logic [16:0] idx;
    logic [7:0]  d, rd;
    int          sel;
    a  = $urandom();
    d  = 8'($urandom());
    rd = 8'($urandom());
    if ($urandom_range(99) < p_io) begin
      a[17:16] = 2'b11;
      sel = $urandom_range(9);
      a[2:0] = (sel < 5) ? 3'd0 : (sel < 8) ? 3'd4 : 3'($urandom_range(7));
    end else begin
      sel = $urandom_range(63);
      idx = (sel < 32) ? 17'h00100 + 17'(sel) : 17'h1FFE0 + 17'(sel - 32);
      a[17]   = 1'b0;
      a[16:0] = idx;
    end
    cycle(a, $urandom_range(99) < p_wr, d, $urandom_range(99) < p_txr, rd, $urandom_range(99) < p_rxv);
  endtask

  int phase_tbl [4][4] = '{'{60, 70, 20, 20}, '{60, 20, 90, 70}, '{30, 50, 50, 50}, '{80, 40, 10, 90}};

  initial begin
    rst = 1'b1; mem_a = A_IDLE; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    do_reset();
    check("reset_mem_din", mem_din, 8'h00);
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_ibf", io_buffer_full, 1'b0);
    check("reset_rx_full", rx_full, 1'b0);
    check("reset_sim_end", sim_end, 1'b0);

    for (int s = 0; s < 64; s++) begin
      logic [16:0] idx;
      idx = (s < 32) ? 17'h00100 + 17'(s) : 17'h1FFE0 + 17'(s - 32);
      cycle({15'h0, idx}, 1'b1, 8'(s) ^ 8'h5A, 1'b0, 8'h00, 1'b0);
    end

    // RAM byte loop
    for (int k = 0; k < 4; k++) cycle(32'h100 + k, 1'b1, 8'h11 * 8'(k + 1), 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(32'h100 + k, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("ram_loop", mem_din, 8'h11 * 8'(k + 1));
    end

    // Read-first
    cycle(A_IDLE, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
    cycle(A_IDLE, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    check("read_first_old", mem_din, 8'hAA);
    cycle(A_IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("read_first_new", mem_din, 8'h55);

    // TX back-pressure and overflow
    for (int k = 0; k < 16; k++) begin
      cycle(A_IO0, 1'b1, 8'h80 + 8'(k), 1'b0, 8'h00, 1'b0);
      if (k == 13) check("ibf_after_14", io_buffer_full, 1'b0);
      if (k == 14) check("ibf_after_15", io_buffer_full, 1'b1);
    end
    check("tx_ovf_before_17", tx_overflow, 1'b0);
    cycle(A_IO0, 1'b1, 8'hEE, 1'b0, 8'h00, 1'b0);
    check("tx_ovf_after_17", tx_overflow, 1'b1);
    for (int k = 0; k < 16; k++) begin
      check("tx_drain_order", tx_data, 8'h80 + 8'(k));
      cycle(A_IDLE, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      if (k == 0) check("ibf_count15", io_buffer_full, 1'b1);
      if (k == 1) check("ibf_count14", io_buffer_full, 1'b0);
    end
    check("tx_drained", tx_valid, 1'b0);

    // Simultaneous push/pop at count 1
    cycle(A_IO0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    cycle(A_IO0, 1'b1, 8'h02, 1'b1, 8'h00, 1'b0);
    check("pushpop_head2", tx_data, 8'h02);
    cycle(A_IO0, 1'b1, 8'h03, 1'b1, 8'h00, 1'b0);
    check("pushpop_head3", tx_data, 8'h03);
    cycle(A_IDLE, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check("pushpop_empty", tx_valid, 1'b0);

    // RX path
    cycle(A_IO0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rx_empty_read", mem_din, 8'h00);
    cycle(A_IDLE, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1);
    cycle(A_IDLE, 1'b0, 8'h00, 1'b0, 8'h42, 1'b1);
    cycle(A_IO4, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rx_status_ne", mem_din, 8'h02);
    cycle(A_IO0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rx_read_41", mem_din, 8'h41);
    cycle(A_IO0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rx_read_42", mem_din, 8'h42);
    cycle(A_IO4, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rx_status_empty", mem_din, 8'h00);
    cycle(A_IO0, 1'b0, 8'h00, 1'b0, 8'h99, 1'b1);
    check("rx_read_push_same", mem_din, 8'h00);
    cycle(A_IO0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rx_read_99", mem_din, 8'h99);

    // RX full and drop
    for (int k = 0; k < 17; k++) begin
      cycle(A_IDLE, 1'b0, 8'h00, 1'b0, 8'hC0 + 8'(k), 1'b1);
      if (k == 14) check("rx_not_full_15", rx_full, 1'b0);
      if (k == 15) check("rx_full_16", rx_full, 1'b1);
    end
    for (int k = 0; k < 16; k++) begin
      cycle(A_IO0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("rx_full_drain", mem_din, 8'hC0 + 8'(k));
    end

    // Reset mid-operation
    for (int k = 0; k < 5; k++) cycle(A_IO0, 1'b1, 8'hB0 + 8'(k), 1'b0, 8'h00, 1'b0);
    cycle(A_IO4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    check("sim_end_set", sim_end, 1'b1);
    do_reset();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_sim_end", sim_end, 1'b0);
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_overflow", tx_overflow, 1'b0);
    cycle(32'h100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rst_ram_kept", mem_din, 8'h11);

    // Randomized phases
    for (int ph = 0; ph < 12; ph++) begin
      for (int i = 0; i < 150; i++)
        rand_cycle(phase_tbl[ph % 4][0], phase_tbl[ph % 4][1], phase_tbl[ph % 4][2], phase_tbl[ph % 4][3]);
      if (ph == 5) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
